md_unit: RTL

- Multiply/divide unit in the Execute stage, alongside the ALU.
- Holds the architectural HI/LO registers.
- Runs mult/multu/div/divu over a fixed multi-cycle latency, and serves mfhi/mflo/mthi/mtlo.
- Its read result is muxed into the E-stage result that feeds the E/M pipeline register. Its busy output drives the hazard unit's stall logic for MD-class instructions.

---
 rtl/md_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// md_unit: Execute-stage multiply/divide unit holding the architectural HI/LO
// registers. mult/multu/div/divu run for a fixed number of cycles and commit
// HI/LO atomically on the final edge; mfhi/mflo read combinationally and
// mthi/mtlo write when the unit is idle.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_V1,
    input  logic [31:0] E_V2,
    input  logic [3:0]  MDOp,
    input  logic        start,
    output logic        busy,
    output logic [31:0] MD_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic             op_unsigned;

    logic        launch_mult;
    logic        launch_div;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic        div_zero;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] div_q;
    logic [31:0] div_r;

    assign launch_mult = start && !busy && (MDOp == 4'd1 || MDOp == 4'd2);
    assign launch_div  = start && !busy && (MDOp == 4'd3 || MDOp == 4'd4);

    // 64-bit product of the latched operands, signed or unsigned
    always_comb begin
        prod = 64'd0;
        if (op_unsigned) begin
            prod = {32'd0, op_a} * {32'd0, op_b};
        end else begin
            prod = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
        end
    end

    // Sign-magnitude divide: quotient truncates toward zero, remainder follows
    // the dividend. 0x80000000 / -1 falls out as LO=0x80000000, HI=0 because the
    // magnitude 0x80000000 is representable unsigned.
    always_comb begin
        a_neg    = !op_unsigned && op_a[31];
        b_neg    = !op_unsigned && op_b[31];
        div_zero = (op_b == 32'd0);
        mag_a    = a_neg ? (~op_a + 32'd1) : op_a;
        mag_b    = b_neg ? (~op_b + 32'd1) : op_b;
        if (div_zero) begin
            mag_b = 32'd1;
        end
        uq    = mag_a / mag_b;
        ur    = mag_a % mag_b;
        div_q = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        div_r = a_neg ? (~ur + 32'd1) : ur;
    end

    // Control FSM plus HI/LO, operand latches and registered busy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            op_a        <= 32'd0;
            op_b        <= 32'd0;
            op_unsigned <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch_mult) begin
                        op_a        <= E_V1;
                        op_b        <= E_V2;
                        op_unsigned <= (MDOp == 4'd2);
                        count       <= MULT_LOAD;
                        state       <= MULT;
                        busy        <= 1'b1;
                    end else if (launch_div) begin
                        op_a        <= E_V1;
                        op_b        <= E_V2;
                        op_unsigned <= (MDOp == 4'd4);
                        count       <= DIV_LOAD;
                        state       <= DIV;
                        busy        <= 1'b1;
                    end else if (MDOp == 4'd7) begin
                        hi <= E_V1;
                    end else if (MDOp == 4'd8) begin
                        lo <= E_V1;
                    end
                end
                MULT: begin
                    if (count == '0) begin
                        hi    <= prod[63:32];
                        lo    <= prod[31:0];
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DIV: begin
                    if (count == '0) begin
                        // A zero divisor still costs the full latency but leaves HI/LO alone
                        if (!div_zero) begin
                            hi <= div_r;
                            lo <= div_q;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read port for mfhi/mflo; HI/LO only change on commit, so this shows the
    // pre-operation value while busy
    always_comb begin
        case (MDOp)
            4'd5:    MD_out = hi;
            4'd6:    MD_out = lo;
            default: MD_out = 32'd0;
        endcase
    end

endmodule
